// File: rtl/sc_bitstream_accum_et_pkg.sv
// Shared types and helpers for the stochastic bitstream accumulator.
package sc_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Run lengths beyond the full-length run are treated as full length.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned cnt_w);
        return (len > cnt_w) ? cnt_w : len;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned cnt_w);
        return idx * (cnt_w + 1);
    endfunction

endpackage

// File: rtl/sc_bitstream_accum_et_if.sv
// Run control, sample input and result handshake of the bitstream accumulator.
interface sc_bitstream_accum_et_if #(
    parameter int NUM_STREAMS = 8,
    parameter int CNT_W       = 8,
    parameter int LEN_W       = $clog2(CNT_W + 1)
);
    logic                             start;
    logic [LEN_W-1:0]                 len_log2;
    logic                             in_valid;
    logic [NUM_STREAMS-1:0]           bits;
    logic                             busy;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_STREAMS*(CNT_W+1)-1:0] result;

    modport master (
        output start, len_log2, in_valid, bits, out_ready,
        input  busy, out_valid, result
    );

    modport slave (
        input  start, len_log2, in_valid, bits, out_ready,
        output busy, out_valid, result
    );
endinterface

// File: rtl/sc_bitstream_accum_et_ones_ctr.sv
// Per-stream ones counter with synchronous clear.
module sc_ones_ctr #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [CNT_W:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + (CNT_W+1)'(bit_in);
        end
    end

endmodule

// File: rtl/sc_bitstream_accum_et.sv
// Counts ones per SC bitstream over 2^len valid samples and presents the
// counts rescaled to the full-length run behind a valid/ready handshake.
module sc_bitstream_accum_et
    import sc_accum_pkg::*;
#(
    parameter  int NUM_STREAMS = 8,
    parameter  int CNT_W       = 8,
    localparam int LEN_W       = $clog2(CNT_W + 1)
) (
    input logic                    clk,
    input logic                    rst_n,
    sc_bitstream_accum_et_if.slave bus
);

    localparam int RES_W = NUM_STREAMS * (CNT_W + 1);

    state_t             state_q, state_d;
    logic               clr, en, load;
    logic [LEN_W-1:0]   len_q, len_next, shamt;
    logic [CNT_W:0]     scnt_q, last_idx;
    logic [CNT_W:0]     cnt [NUM_STREAMS];
    logic [RES_W-1:0]   result_q, result_d;

    assign len_next = LEN_W'(clamp_len(32'(bus.len_log2), CNT_W));
    assign last_idx = ((CNT_W+1)'(1) << len_q) - (CNT_W+1)'(1);
    assign shamt    = LEN_W'(CNT_W) - len_q;

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
        sc_ones_ctr #(.CNT_W(CNT_W)) u_ctr (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clr),
            .en     (en),
            .bit_in (bus.bits[g]),
            .cnt    (cnt[g])
        );
        // Include the sample being accepted so the result lands on the same edge.
        assign result_d[slice_lo(g, CNT_W) +: CNT_W+1] =
            (cnt[g] + (CNT_W+1)'(bus.bits[g])) << shamt;
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.in_valid) begin
                    en = 1'b1;
                    if (scnt_q == last_idx) begin
                        load    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        clr     = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the result registers are reset too, so nothing stale is visible
    // after a reset that interrupts a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            scnt_q   <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                len_q  <= len_next;
                scnt_q <= '0;
            end else if (en) begin
                scnt_q <= scnt_q + (CNT_W+1)'(1);
            end
            if (load) begin
                result_q <= result_d;
            end
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;

endmodule

// File: doc/sc_bitstream_accum_et.md
Name: sc_bitstream_accum_et

Overview:
- Downstream stage of the stochastic-number generators. It accepts NUM_STREAMS parallel SC bitstreams, one bit per stream per cycle, and counts the ones in each stream over a run of 2^len_log2 valid samples.
- Early-terminated (short) runs are rescaled by a left shift so every result is on the full-length scale (2^CNT_W samples).
- Results are held behind a valid/ready handshake until consumed.

Parameters:
- NUM_STREAMS, 8, number of parallel bitstreams counted.
- CNT_W, 8, log2 of the full-length run; results are CNT_W+1 bits wide.
- LEN_W, $clog2(CNT_W+1), width of len_log2 (derived; do not override).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a run; sampled only in IDLE, or in DONE when out_ready=1 in the same cycle.
- len_log2  input  LEN_W  log2 of the run length; latched on accepted start; values >CNT_W clamp to CNT_W.
- in_valid  input  1  bits is a valid sample this cycle.
- bits  input  NUM_STREAMS  one SC bit per stream.
- busy  output  1  high in RUN.
- out_valid  output  1  high in DONE.
- out_ready  input  1  consumer accepts results.
- result  output  NUM_STREAMS*(CNT_W+1)  packed; stream i occupies bits [i*(CNT_W+1) +: CNT_W+1].

Behaviour:
- Reset (async, rst_n low): state=IDLE, all ones counters=0, sample counter=0, latched len=0. Outputs busy=0, out_valid=0, result=0. Reset mid-run discards the run; no partial result appears.
- FSM states and transitions:
  - IDLE: on start, latch clamp(len_log2), clear all counters, go to RUN.
  - RUN: each cycle with in_valid=1:
    - cnt[i] += bits[i] for every stream.
    - scnt += 1.
    - If scnt == 2^len-1 before the increment (final sample), go to DONE.
  - RUN: in_valid=0 leaves all state unchanged. start is ignored.
  - DONE: out_valid=1 and result is stable.
    - out_ready=1 and start=0: go to IDLE.
    - out_ready=1 and start=1: relatch len, clear counters, go to RUN (back-to-back, no bubble).
    - out_ready=0: hold; start and in_valid are ignored.
- Counter widths:
  - Ones counters and scnt are CNT_W+1 bits wide, so no overflow is possible (max count 2^CNT_W).
  - The sample counter compare uses the latched len.
- Scaling:
  - result_i = cnt[i] << (CNT_W - len), truncated to CNT_W+1 bits. This never loses bits because cnt[i] ≤ 2^len.
  - Scaled results are registered on entry to DONE. result must not change while out_valid=1.
- Latency:
  - out_valid rises on the clock edge that accepts the final sample, so it is visible the cycle after that sample is presented.
  - A len=0 run takes 1 valid sample.
- In IDLE, in_valid and bits are ignored. result keeps the last value (0 after reset).

Decomposition:
- Package sc_accum_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - Function clamp_len(len, CNT_W).
  - Function for the result slice offset.
- Sub-module sc_ones_ctr (one per stream, generate array):
  - Ports: clk, rst_n, clr, en, bit_in, cnt[CNT_W:0].
  - Synchronous clear; increments by bit_in when en.
- Top level holds the FSM, the sample counter, the shifters and the result registers.

Test Plan:
- Single-sample run: len_log2=0, start, then one sample with bits=8'hA5 → out_valid next cycle; streams 0,2,5,7 = 256, all others = 0.
- Short run with gaps: len_log2=3, 8 valid samples interleaved with random in_valid=0 gaps; stream0 all ones, stream1 alternating 1/0, stream2 zeros → results 256, 128, 0. out_valid rises exactly 1 cycle after the 8th valid sample.
- Full run and clamp: len_log2=15 (clamps to 8), 256 samples, stream3=1 on samples 0..63 only → busy for exactly 256 valid samples; result3=64, no shift.
- Backpressure: in DONE, hold out_ready=0 for 5 cycles while toggling start, in_valid and bits → result and out_valid stable, no new run. Then out_ready=1 with start=1, len=1 → RUN next cycle; a 2-sample run gives correct fresh counts (old counts fully cleared).
- Reset mid-run: len=4, assert rst_n low after 7 samples → all outputs 0 immediately (async). After release, a new len=2 run with bits=all-ones → every stream = 256.
- Idle immunity: in IDLE, drive in_valid=1 and bits=8'hFF for 10 cycles, then run len=1 with bits=0 → all results 0.
